// File: rtl/port_pkt_reader_if.sv
// Handshake bundle between port_pkt_reader, its port FIFO and the downstream sink.
// master: the reader (pops the FIFO, drives the stream); slave: FIFO/sink side.
interface port_pkt_reader_if #(
  parameter int unsigned W_WIDTH = 8
) ();

  // Port FIFO side
  logic [W_WIDTH-1:0] port_out;
  logic               port_rdy;
  logic               port_rd;

  // Downstream stream side
  logic [W_WIDTH-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sop;
  logic               out_eop;
  logic               addr_err;

  modport master (
    input  port_out,
    input  port_rdy,
    input  out_ready,
    output port_rd,
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    output addr_err
  );

  modport slave (
    output port_out,
    output port_rdy,
    output out_ready,
    input  port_rd,
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    input  addr_err
  );

endinterface

// File: rtl/port_pkt_reader.sv
// Port packet reader: pops words from a port FIFO, parses address/length/payload framing,
// tags sop/eop and streams the words downstream through a 2-entry buffer with bypass.
// Optional statistics counters are built when PORT_PKT_READER_STATS_EN is defined.
module port_pkt_reader #(
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned PORT_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,   // active-high asynchronous reset
  port_pkt_reader_if.master  bus_io
`ifdef PORT_PKT_READER_STATS_EN
  ,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        err_cnt
`endif
);

  localparam logic [W_WIDTH-1:0] PortAddrW = W_WIDTH'(PORT_ADDR);

  typedef enum logic [1:0] {StAddr, StLen, StPayload} state_e;

  state_e             state_q, state_d;
  logic [W_WIDTH-1:0] rem_q, rem_d;
  logic               addr_err_q, addr_err_d;

  // A pop issued last cycle means port_out carries a fresh word this cycle
  logic               rd_inflight_q;
  logic               port_rd;

  logic [1:0]         count_q, count_d;
  logic               rd_ptr_q, wr_ptr_q;
  logic [W_WIDTH-1:0] mem_data_q [2];
  logic [1:0]         mem_sop_q, mem_eop_q;

  logic               capture, accept, wr_en, pop_en;
  logic               tag_sop, tag_eop;
  logic [2:0]         occ_after;

  logic [W_WIDTH-1:0] out_data;
  logic               out_valid, out_sop, out_eop;

  assign capture = rd_inflight_q;

  // Parser next state and sop/eop tags for the word on port_out
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    addr_err_d = 1'b0;
    tag_sop    = 1'b0;
    tag_eop    = 1'b0;
    unique case (state_q)
      StAddr: begin
        tag_sop = 1'b1;
        if (capture) begin
          state_d    = StLen;
          addr_err_d = (bus_io.port_out != PortAddrW);
        end
      end
      StLen: begin
        tag_eop = (bus_io.port_out == '0);
        if (capture) begin
          rem_d   = bus_io.port_out;
          state_d = (bus_io.port_out == '0) ? StAddr : StPayload;
        end
      end
      StPayload: begin
        tag_eop = (rem_q == W_WIDTH'(1));
        if (capture) begin
          rem_d = rem_q - W_WIDTH'(1);
          if (rem_q == W_WIDTH'(1)) begin
            state_d = StAddr;
          end
        end
      end
      default: state_d = StAddr;
    endcase
  end

  // Parser state, remaining-word counter and address-error pulse
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= StAddr;
      rem_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Present the buffer head, or bypass the captured word when the buffer is empty
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    if (count_q != 2'd0) begin
      out_data  = mem_data_q[rd_ptr_q];
      out_sop   = mem_sop_q[rd_ptr_q];
      out_eop   = mem_eop_q[rd_ptr_q];
      out_valid = 1'b1;
    end else if (capture) begin
      out_data  = bus_io.port_out;
      out_sop   = tag_sop;
      out_eop   = tag_eop;
      out_valid = 1'b1;
    end
  end

  // Buffer bookkeeping and the pop decision; a same-cycle accept frees a slot
  always_comb begin
    accept    = out_valid & bus_io.out_ready;
    // A bypassed word that is accepted immediately never enters the buffer
    wr_en     = capture & ~((count_q == 2'd0) & accept);
    pop_en    = accept & (count_q != 2'd0);
    count_d   = count_q + 2'(wr_en) - 2'(pop_en);
    occ_after = 3'(count_q) + 3'(rd_inflight_q) - 3'(accept);
    port_rd   = ~bus_io.port_rdy & (occ_after < 3'd2);
  end

  // Output buffer storage, pointers and in-flight read tracking
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_inflight_q <= 1'b0;
      mem_sop_q     <= 2'b00;
      mem_eop_q     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
      end
    end else begin
      rd_inflight_q <= port_rd;
      count_q       <= count_d;
      if (wr_en) begin
        mem_data_q[wr_ptr_q] <= bus_io.port_out;
        mem_sop_q[wr_ptr_q]  <= tag_sop;
        mem_eop_q[wr_ptr_q]  <= tag_eop;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign bus_io.port_rd   = port_rd;
  assign bus_io.out_data  = out_data;
  assign bus_io.out_valid = out_valid;
  assign bus_io.out_sop   = out_sop;
  assign bus_io.out_eop   = out_eop;
  assign bus_io.addr_err  = addr_err_q;

`ifdef PORT_PKT_READER_STATS_EN
  logic [15:0] pkt_cnt_q, err_cnt_q;

  // Packet and address-error counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pkt_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      if (accept && out_eop) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (addr_err_q) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_port_pkt_reader.sv
// Self-checking bench for port_pkt_reader: behavioural port FIFO plus a scoreboard of
// expected {data, sop, eop} words pushed alongside the stimulus.
module tb_port_pkt_reader;

  logic clk;
  logic rst_n;

  port_pkt_reader_if #(.W_WIDTH(8)) bus ();

`ifdef PORT_PKT_READER_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
`endif

  port_pkt_reader #(
    .W_WIDTH  (8),
    .PORT_ADDR(0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
`ifdef PORT_PKT_READER_STATS_EN
    ,
    .pkt_cnt(pkt_cnt),
    .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  logic [9:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int rd_cnt, err_seen, rd_empty_viol, stable_viol, underflow;
  int first_rd_cyc, first_acc_cyc, last_acc_cyc;
  bit rand_rdy = 1'b0;
  bit prev_stall = 1'b0;
  logic [9:0] prev_word;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_stats();
    rd_cnt        = 0;
    err_seen      = 0;
    rd_empty_viol = 0;
    stable_viol   = 0;
    first_rd_cyc  = -1;
    first_acc_cyc = -1;
    last_acc_cyc  = -1;
  endtask

  task automatic push_word(input logic [7:0] w, input logic sop, input logic eop);
    fifo.push_back(w);
    exp_q.push_back({w, sop, eop});
    bus.port_rdy = 1'b0;
  endtask

  task automatic push_pkt(input logic [7:0] addr, input int len, input logic [7:0] base);
    push_word(addr, 1'b1, 1'b0);
    push_word(8'(len), 1'b0, len == 0);
    for (int i = 0; i < len; i++) begin
      push_word(base + 8'(i), 1'b0, i == len - 1);
    end
  endtask

  // One clock: monitor at negedge, FIFO model and input updates 1 time unit after posedge
  task automatic tick();
    logic       pop_req;
    logic [9:0] cur;
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    cur = {bus.out_data, bus.out_sop, bus.out_eop};
    if (bus.port_rd) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (bus.port_rdy) rd_empty_viol++;
    end
    if (bus.addr_err) err_seen++;
    if (prev_stall && (!bus.out_valid || cur !== prev_word)) stable_viol++;
    prev_stall = bus.out_valid && !bus.out_ready && !rst_n;
    prev_word  = cur;
    if (bus.out_valid && bus.out_ready) begin
      check_eq("sb_has_word", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("out_word", cur, e);
      end
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    pop_req = bus.port_rd;
    @(posedge clk);
    #1;
    if (pop_req) begin
      if (fifo.size() == 0) underflow++;
      else bus.port_out = fifo.pop_front();
    end
    bus.port_rdy = (fifo.size() == 0);
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) != 0);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || fifo.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    check_eq("drain_done", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_port_rd"}, bus.port_rd, 0);
    check_eq({tag, "_valid"}, bus.out_valid, 0);
    check_eq({tag, "_data"}, bus.out_data, 0);
    check_eq({tag, "_sop"}, bus.out_sop, 0);
    check_eq({tag, "_eop"}, bus.out_eop, 0);
    check_eq({tag, "_addr_err"}, bus.addr_err, 0);
  endtask

  initial begin
    underflow     = 0;
    rst_n         = 1'b1;
    bus.port_out  = 8'h00;
    bus.port_rdy  = 1'b1;
    bus.out_ready = 1'b1;
    clear_stats();
    repeat (2) tick();
    check_idle("reset");
    rst_n = 1'b0;
    repeat (2) tick();

    // Basic packet, full throughput, 1-cycle latency
    clear_stats();
    push_pkt(8'h00, 2, 8'hA1);
    drain(50);
    check_eq("t1_addr_err", err_seen, 0);
    check_eq("t1_back_to_back", last_acc_cyc - first_acc_cyc, 3);
    check_eq("t1_latency", first_acc_cyc - first_rd_cyc, 1);
    check_eq("t1_pops", rd_cnt, 4);

    // Wrong address, zero length
    clear_stats();
    push_pkt(8'h05, 0, 8'h00);
    drain(50);
    check_eq("t2_addr_err", err_seen, 1);
`ifdef PORT_PKT_READER_STATS_EN
    check_eq("t2_err_cnt", err_cnt, 1);
    check_eq("t2_pkt_cnt", pkt_cnt, 2);
`endif

    // Back-to-back packets
    clear_stats();
    push_pkt(8'h00, 0, 8'h00);
    push_pkt(8'h00, 1, 8'h33);
    drain(50);
    check_eq("t3_addr_err", err_seen, 0);
`ifdef PORT_PKT_READER_STATS_EN
    check_eq("t3_pkt_cnt", pkt_cnt, 4);
`endif

    // Downstream stall: two pops fill the buffer, output holds
    clear_stats();
    bus.out_ready = 1'b0;
    push_pkt(8'h00, 3, 8'h11);
    repeat (5) tick();
    check_eq("t4_pops_stalled", rd_cnt, 2);
    check_eq("t4_hold_valid", bus.out_valid, 1);
    check_eq("t4_hold_data", bus.out_data, 8'h00);
    check_eq("t4_hold_sop", bus.out_sop, 1);
    check_eq("t4_stable", stable_viol, 0);
    bus.out_ready = 1'b1;
    drain(50);
    check_eq("t4_pops_total", rd_cnt, 5);

    // FIFO runs dry mid-payload
    clear_stats();
    push_word(8'h00, 1'b1, 1'b0);
    push_word(8'h04, 1'b0, 1'b0);
    push_word(8'hC0, 1'b0, 1'b0);
    push_word(8'hC1, 1'b0, 1'b0);
    repeat (8) tick();
    check_eq("t5_pops_dry", rd_cnt, 4);
    check_eq("t5_rd_while_empty", rd_empty_viol, 0);
    push_word(8'hC2, 1'b0, 1'b0);
    push_word(8'hC3, 1'b0, 1'b1);
    drain(50);
    check_eq("t5_pops_total", rd_cnt, 6);

    // Maximum length packet
    clear_stats();
    push_pkt(8'h00, 255, 8'h00);
    drain(600);
    check_eq("t6_pops", rd_cnt, 257);

    // Random backpressure across several packets
    clear_stats();
    rand_rdy = 1'b1;
    push_pkt(8'h00, 2, 8'h10);
    push_pkt(8'h07, 5, 8'h20);
    push_pkt(8'h00, 0, 8'h00);
    push_pkt(8'h00, 1, 8'h40);
    push_pkt(8'h09, 3, 8'h50);
    drain(500);
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("t7_addr_err", err_seen, 2);
    check_eq("t7_stable", stable_viol, 0);
    check_eq("t7_rd_while_empty", rd_empty_viol, 0);
`ifdef PORT_PKT_READER_STATS_EN
    check_eq("t7_pkt_cnt", pkt_cnt, 12);
    check_eq("t7_err_cnt", err_cnt, 3);
`endif

    // Reset after the length word abandons the packet
    clear_stats();
    bus.out_ready = 1'b0;
    push_pkt(8'h00, 3, 8'h60);
    repeat (4) tick();
    check_eq("t8_pops_before_rst", rd_cnt, 2);
    rst_n = 1'b1;
    fifo.delete();
    exp_q.delete();
    bus.port_rdy = 1'b1;
    #1;
    check_idle("t8_rst");
    repeat (2) tick();
    check_idle("t8_rst_hold");
    rst_n = 1'b0;
    clear_stats();
    bus.out_ready = 1'b1;
    push_pkt(8'h00, 1, 8'h7F);
    drain(50);
    check_eq("t8_addr_err", err_seen, 0);
    check_eq("t8_pops", rd_cnt, 3);
`ifdef PORT_PKT_READER_STATS_EN
    check_eq("t8_pkt_cnt", pkt_cnt, 1);
    check_eq("t8_err_cnt", err_cnt, 0);
`endif

    check_eq("fifo_underflow", underflow, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
